// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Holds the arbiter state enum, default widths and a counter-width helper.
package dmem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    CORE,
    HOST,
    LOCKED
  } arb_state_t;

  function automatic int cnt_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating counter of cycles a host request has lost to the core.
// Ports: clk, reset (async low), inc, clr (wins over inc), cnt.
module starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIM = 4,
  parameter int W   = cnt_w(LIM)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIM_V = W'(LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIM_V) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port data memory between the core and a host.
// Ports: core/host request sides, registered read returns, memory port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic [DW-1:0] core_rdata,
  output logic          core_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int SW = cnt_w(STARVE_LIM);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit;

  assign starve_hit = (starve_cnt >= SW'(STARVE_LIM));

  starve_ctr #(
    .LIM (STARVE_LIM),
    .W   (SW)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (host_req & ~host_gnt),
    .clr   (~host_req | host_gnt),
    .cnt   (starve_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOCKED: begin
        state_nxt = host_lock ? LOCKED : IDLE;
      end
      default: begin
        unique case (1'b1)
          host_gnt: state_nxt = host_lock ? LOCKED : HOST;
          core_gnt: state_nxt = CORE;
          default:  state_nxt = IDLE;
        endcase
      end
    endcase
  end

  // Grants are gated by reset so nothing reaches memory while it is held.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (reset) begin
      unique case (state)
        LOCKED: begin
          host_gnt = host_req;
        end
        default: begin
          if (core_req && host_req) begin
            host_gnt = starve_hit;
            core_gnt = ~starve_hit;
          end else begin
            core_gnt = core_req;
            host_gnt = host_req;
          end
        end
      endcase
    end
  end

  assign core_stall = reset & core_req & ~core_gnt;

  always_comb begin
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (core_gnt) begin
      mem_wr_en  = core_we;
      mem_addr   = core_addr;
      mem_dat_in = core_wdata;
    end else if (host_gnt) begin
      mem_wr_en  = host_we;
      mem_addr   = host_addr;
      mem_dat_in = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      core_rvalid <= core_gnt & ~core_we;
      host_rvalid <= host_gnt & ~host_we;
      if (core_gnt && !core_we) begin
        core_rdata <= mem_dat_out;
      end
      if (host_gnt && !host_we) begin
        host_rdata <= mem_dat_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter.
// Compares the DUT each cycle against a rule-level reference model.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic       clk;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_stall;
  logic [7:0] core_rdata;
  logic       core_rvalid;
  logic       host_req, host_we, host_lock;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;

  dmem_arbiter #(
    .AW(8), .DW(8), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_we(host_we),
    .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dmem [256];
  assign mem_dat_out = dmem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) dmem[mem_addr] <= mem_dat_in;
  end

  int n_chk;
  int n_pass;

  logic [7:0] ref_mem [256];
  bit         m_locked;
  int         m_wait;
  bit         exp_crv, exp_hrv;
  logic [7:0] exp_crd, exp_hrd;
  bit         obs_cg, obs_hg, obs_stall;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [7:0] cd, input bit hr, input bit hw,
                       input bit hl, input logic [7:0] ha,
                       input logic [7:0] hd);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_lock = hl;
    host_addr = ha; host_wdata = hd;
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_wait   = 0;
    exp_crv  = 0;
    exp_hrv  = 0;
    exp_crd  = 8'h00;
    exp_hrd  = 8'h00;
  endtask

  task automatic step();
    bit         cg, hg, ewe;
    logic [7:0] ea, ed;
    @(negedge clk);
    chk("core_rvalid", core_rvalid, exp_crv);
    chk("core_rdata", core_rdata, exp_crd);
    chk("host_rvalid", host_rvalid, exp_hrv);
    chk("host_rdata", host_rdata, exp_hrd);
    if (m_locked) begin
      hg = host_req;
      cg = 0;
    end else if (core_req && host_req) begin
      hg = (m_wait >= LIM);
      cg = !hg;
    end else begin
      cg = core_req;
      hg = host_req;
    end
    ewe = cg ? core_we : (hg ? host_we : 1'b0);
    ea  = cg ? core_addr : (hg ? host_addr : 8'h00);
    ed  = cg ? core_wdata : (hg ? host_wdata : 8'h00);
    chk("core_gnt", core_gnt, cg);
    chk("host_gnt", host_gnt, hg);
    chk("core_stall", core_stall, core_req && !cg);
    chk("mem_wr_en", mem_wr_en, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_dat_in", mem_dat_in, ed);
    obs_cg    = core_gnt;
    obs_hg    = host_gnt;
    obs_stall = core_stall;
    exp_crv = cg && !core_we;
    if (exp_crv) exp_crd = ref_mem[core_addr];
    exp_hrv = hg && !host_we;
    if (exp_hrv) exp_hrd = ref_mem[host_addr];
    if (cg && core_we) ref_mem[core_addr] = core_wdata;
    if (hg && host_we) ref_mem[host_addr] = host_wdata;
    if (host_req && !hg) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
    else m_wait = 0;
    m_locked = m_locked ? host_lock : (hg && host_lock);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cgnt"}, core_gnt, 0);
    chk({tag, "_hgnt"}, host_gnt, 0);
    chk({tag, "_we"}, mem_wr_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_din"}, mem_dat_in, 0);
    chk({tag, "_crv"}, core_rvalid, 0);
    chk({tag, "_hrv"}, host_rvalid, 0);
    chk({tag, "_crd"}, core_rdata, 0);
    chk({tag, "_hrd"}, host_rdata, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    dmem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    dmem[8'h01] = 8'h3C; ref_mem[8'h01] = 8'h3C;
    dmem[8'h02] = 8'hC3; ref_mem[8'h02] = 8'hC3;
    drive(1, 1, 8'h44, 8'h55, 1, 1, 1, 8'h66, 8'h77);
    #12;
    chk_reset_outs("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // core-only read right after reset release
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();
    chk("t32_gnt", obs_cg, 1);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();
    step();
    chk("t32_hold", core_rdata, 8'hA5);

    // both requesting: host forced through on the fifth cycle
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      step();
      chk("t33_host", obs_hg, (i == 4));
      chk("t33_stall", obs_stall, (i == 4));
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();

    // locked host write burst while the core keeps asking
    for (int i = 0; i < 4; i++) begin
      drive(i != 0, 0, 8'h20, 8'h00, 1, 1, 1, 8'(i), 8'(i + 1));
      step();
      chk("t34_hgnt", obs_hg, 1);
      if (i != 0) chk("t34_stall", obs_stall, 1);
    end
    drive(1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();
    chk("t34_drop", obs_stall, 1);
    step();
    chk("t34_core", obs_cg, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t34_mem", dmem[i], 8'(i + 1));
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();

    // alternating single requesters
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive(1, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      else drive(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      step();
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();

    // reset in the cycle after a locked host read grant
    drive(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h02, 8'h00);
    step();
    drive(1, 1, 8'h33, 8'h44, 1, 1, 1, 8'h55, 8'h66);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outs("t36");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();
    chk("t36_idle", obs_cg, 1);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            8'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0,
            8'($urandom_range(0, 15)), 8'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning data-memory address width.
REQ-002 SHALL have parameter DW, default 8, meaning data width.
REQ-003 SHALL have parameter STARVE_LIM, default 4, meaning cycles a pending host request may lose to the core before it is forced through.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 core_req / core_we  input  1 / 1  core access request / write qualifier.
REQ-007 core_addr / core_wdata  input  AW / DW  core address / write data.
REQ-008 core_gnt / core_stall  output  1 / 1  core access accepted this cycle / core must hold PC and request.
REQ-009 core_rdata / core_rvalid  output  DW / 1  core read data / valid pulse.
REQ-010 host_req / host_we / host_lock  input  1 / 1 / 1  host (loader/bench) request / write qualifier / burst-ownership request.
REQ-011 host_addr / host_wdata  input  AW / DW  host address / write data.
REQ-012 host_gnt / host_rdata / host_rvalid  output  1 / DW / 1  host accepted / read data / valid pulse.
REQ-013 mem_wr_en / mem_addr / mem_dat_in  output  1 / AW / DW  single-port memory write enable / address / write data.
REQ-014 mem_dat_out  input  DW  combinational read data from memory.

Function
REQ-015 SHALL implement FSM states IDLE, CORE, HOST, LOCKED; exactly one requester drives the memory port per cycle.
REQ-016 IDLE/CORE/HOST: a grant decision is made each cycle; only core_req -> CORE; only host_req -> HOST; neither -> IDLE.
REQ-017 When both request, SHALL grant core unless starve_cnt >= STARVE_LIM, then grant host.
REQ-018 starve_cnt SHALL increment (saturating at STARVE_LIM) each cycle host_req is high and host is not granted, and clear on any host grant or when host_req is low.
REQ-019 host_req with host_lock high, when granted, SHALL enter LOCKED; LOCKED grants host every cycle host_req is high, core_gnt=0, core_stall=core_req.
REQ-020 LOCKED SHALL exit to IDLE in the cycle after host_lock falls; in-flight read still returns.
REQ-021 core_gnt/host_gnt SHALL be combinational from state and inputs in the grant cycle; mem_addr, mem_wr_en=we&gnt, mem_dat_in SHALL mux from the granted requester; unselected -> zeros.
REQ-022 Read (gnt & !we) SHALL register mem_dat_out into the requester's rdata and pulse its rvalid exactly one cycle later (latency 1).
REQ-023 rdata SHALL hold its last value when rvalid is low; writes SHALL NOT pulse rvalid.
REQ-024 core_stall SHALL equal core_req & !core_gnt.
REQ-025 Back-to-back grants to alternating requesters SHALL incur no idle cycle.

Reset
REQ-026 Reset low SHALL asynchronously force state IDLE, starve_cnt 0, both rvalid 0, both rdata 0; grant/mem outputs 0 while reset low.
REQ-027 Reset during an access SHALL drop the access; no rvalid for it after release.
REQ-028 First grant SHALL be possible on the first posedge after reset deasserts.

Structure
REQ-029 Shared package dmem_arb_pkg SHALL hold the state enum type and the default AW/DW constants.
REQ-030 Starvation counter SHALL be one sub-module, starve_ctr (saturating counter with inc/clr).
REQ-031 Block sits between the core's Control outputs (mem_addr, mem_in, MemWrite) and dat_mem; core_stall feeds the PC hold.

Verification
REQ-032 Core-only read addr 8'h10, mem holds 8'hA5 -> core_gnt same cycle, core_rvalid next cycle, core_rdata=8'hA5.
REQ-033 Both requesting continuously, STARVE_LIM=4 -> core granted 4 cycles, host granted 5th, then core again; core_stall=1 only in 5th cycle.
REQ-034 Host write burst with host_lock, addrs 0..3 data 1..4, core_req held high -> core_stall=1 throughout, mem 0..3 = 1..4, core granted cycle after lock drop.
REQ-035 Alternating single requests core read 8'h01, host read 8'h02 -> each rvalid on its own port only, one cycle after its grant.
REQ-036 Reset asserted in cycle after a host read grant -> no host_rvalid, state IDLE, all outputs 0.
